tinyqv_fetch_buffer: RTL and testbench

- Instruction prefetch buffer that sits directly upstream of the decoder/core pair.
- Accepts a stream of 16-bit halfwords from the memory controller and queues them.
- Presents one complete instruction (32-bit, or 16-bit compressed) with its PC, and advances when the core signals instr_complete.
- Flushes and restarts the memory stream when the core branches.

---
 rtl/tinyqv_fetch_buffer.sv | 116 +++++++++++
 tb/tb_tinyqv_fetch_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_fetch_buffer.sv
// Instruction prefetch buffer: queues halfwords from the memory controller and
// presents one complete (32-bit or compressed 16-bit) instruction with its PC.
module tinyqv_fetch_buffer #(
  parameter int unsigned BUF_HALFWORDS = 4,
  parameter logic [22:0] RESET_ADDR    = 23'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] hw_data,
  input  logic        hw_valid,
  output logic        hw_ready,
  output logic        fetch_start,
  output logic        fetch_stop,
  output logic [22:0] fetch_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        instr_compressed,
  output logic [22:0] pc_out,
  input  logic        instr_complete,
  input  logic        branch,
  input  logic [22:0] branch_addr
);

  localparam int unsigned CW = $clog2(BUF_HALFWORDS) + 1;

  typedef enum logic [1:0] {StIdle, StFlush, StStart, StStream} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [22:0]   pc_q, pc_d;
  logic [15:0]   slot_q [BUF_HALFWORDS];
  logic [15:0]   slot_d [BUF_HALFWORDS];

  logic          compressed;
  logic          have_instr;
  logic          push;
  logic          pop;
  logic [CW-1:0] pop_n;
  logic [CW-2:0] push_idx;

  // Instruction formation and handshake qualifiers from registered contents.
  always_comb begin
    compressed       = slot_q[0][1:0] != 2'b11;
    have_instr       = compressed ? (count_q >= CW'(1)) : (count_q >= CW'(2));
    instr_valid      = (state_q == StStream) && have_instr;
    instr_compressed = compressed;
    instr_out        = compressed ? {16'h0000, slot_q[0]} : {slot_q[1], slot_q[0]};
    pc_out           = pc_q;
    hw_ready         = (state_q == StStream) && (count_q < CW'(BUF_HALFWORDS));
    // Branch wins over both sides of the queue.
    push             = hw_valid && hw_ready && !branch;
    pop              = instr_complete && instr_valid && !branch;
    pop_n            = pop ? (compressed ? CW'(1) : CW'(2)) : CW'(0);
    push_idx         = (CW-1)'(count_q - pop_n);
  end

  // Next-state logic: FSM sequencing, queue shift/insert and PC advance.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pc_d        = pc_q;
    slot_d      = slot_q;
    fetch_start = 1'b0;
    fetch_stop  = 1'b0;
    fetch_addr  = 23'h0;

    unique case (state_q)
      StIdle:   state_d = StStart;
      StFlush: begin
        fetch_stop = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        fetch_start = 1'b1;
        fetch_addr  = pc_q;
        state_d     = StStream;
      end
      StStream: state_d = StStream;
      default:  state_d = StIdle;
    endcase

    if (branch && (state_q != StIdle)) begin
      state_d = StFlush;
      count_d = '0;
      pc_d    = branch_addr;
    end else begin
      // Wrapped source index only fills slots above the new count, which are unused.
      for (int unsigned i = 0; i < BUF_HALFWORDS; i++) begin
        slot_d[i] = slot_q[(i + 32'(pop_n)) % BUF_HALFWORDS];
      end
      if (push) begin
        slot_d[push_idx] = hw_data;
      end
      count_d = count_q + (push ? CW'(1) : CW'(0)) - pop_n;
      pc_d    = pc_q + 23'(pop_n);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      count_q <= '0;
      pc_q    <= RESET_ADDR;
      for (int unsigned i = 0; i < BUF_HALFWORDS; i++) begin
        slot_q[i] <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// Self-checking bench for tinyqv_fetch_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tinyqv_fetch_buffer;

  localparam int unsigned BUF = 4;
  localparam logic [22:0] RST_PC = 23'h000000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] hw_data;
  logic        hw_valid;
  logic        hw_ready;
  logic        fetch_start;
  logic        fetch_stop;
  logic [22:0] fetch_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_compressed;
  logic [22:0] pc_out;
  logic        instr_complete;
  logic        branch;
  logic [22:0] branch_addr;

  int passed = 0;
  int total  = 0;

  tinyqv_fetch_buffer #(
    .BUF_HALFWORDS(BUF),
    .RESET_ADDR   (RST_PC)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .hw_data         (hw_data),
    .hw_valid        (hw_valid),
    .hw_ready        (hw_ready),
    .fetch_start     (fetch_start),
    .fetch_stop      (fetch_stop),
    .fetch_addr      (fetch_addr),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid),
    .instr_compressed(instr_compressed),
    .pc_out          (pc_out),
    .instr_complete  (instr_complete),
    .branch          (branch),
    .branch_addr     (branch_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) assert (dut.count_q <= BUF) else $error("FAIL count_bound count=%0d", dut.count_q);
  end

  // Reference model: halfword queue, PC, and restart phase.
  localparam int MIdle = 0, MFlush = 1, MStart = 2, MStream = 3;
  logic [15:0] mq[$];
  logic [22:0] mpc;
  int          mmode;

  function automatic bit m_comp();
    logic [15:0] h;
    if (mq.size() == 0) return 1'b0;
    h = mq[0];
    return h[1:0] != 2'b11;
  endfunction

  function automatic bit m_valid();
    if (mmode != MStream) return 1'b0;
    return (mq.size() >= 1 && m_comp()) || mq.size() >= 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic update_model();
    bit v, c, rdy;
    if (!rstn) begin
      mq.delete();
      mpc   = RST_PC;
      mmode = MIdle;
    end else if (branch && mmode != MIdle) begin
      mq.delete();
      mpc   = branch_addr;
      mmode = MFlush;
    end else begin
      v   = m_valid();
      c   = m_comp();
      rdy = (mmode == MStream) && (mq.size() < BUF);
      if (instr_complete && v) begin
        void'(mq.pop_front());
        if (!c) void'(mq.pop_front());
        mpc = mpc + (c ? 23'd1 : 23'd2);
      end
      if (hw_valid && rdy) mq.push_back(hw_data);
      if (mmode != MStream) mmode = (mmode == MStart) ? MStream : MStart;
    end
  endtask

  task automatic check_model();
    logic [31:0] exp_instr;
    bit v;
    v = m_valid();
    chk("hw_ready", 32'(hw_ready), 32'((mmode == MStream) && (mq.size() < BUF)));
    chk("fetch_stop", 32'(fetch_stop), 32'(mmode == MFlush));
    chk("fetch_start", 32'(fetch_start), 32'(mmode == MStart));
    chk("fetch_addr", 32'(fetch_addr), (mmode == MStart) ? 32'(mpc) : 32'h0);
    chk("instr_valid", 32'(instr_valid), 32'(v));
    chk("pc_out", 32'(pc_out), 32'(mpc));
    if (v) begin
      exp_instr = m_comp() ? {16'h0, mq[0]} : {mq[1], mq[0]};
      chk("instr_out", instr_out, exp_instr);
      chk("instr_compressed", 32'(instr_compressed), 32'(m_comp()));
    end
  endtask

  // Inputs are already set; model follows the coming edge, then outputs are checked.
  task automatic tick();
    update_model();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit c);
    hw_valid       = v;
    hw_data        = d;
    instr_complete = c;
    branch         = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; hw_data = 16'h0; hw_valid = 1'b0; instr_complete = 1'b0;
    branch = 1'b0; branch_addr = 23'h0;
    mq.delete(); mpc = RST_PC; mmode = MIdle;
    @(negedge clk);
    tick();
    tick();
    chk("rst_fetch_start", 32'(fetch_start), 32'h0);
    chk("rst_fetch_stop", 32'(fetch_stop), 32'h0);
    chk("rst_fetch_addr", 32'(fetch_addr), 32'h0);
    chk("rst_hw_ready", 32'(hw_ready), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'(RST_PC));

    // Reset release: IDLE, then one START cycle, then streaming.
    rstn = 1'b1;
    drive(0, 16'h0, 0);
    chk("start_pulse", 32'(fetch_start), 32'h1);
    chk("start_addr", 32'(fetch_addr), 32'h0);
    chk("start_ready", 32'(hw_ready), 32'h0);
    drive(0, 16'h0, 0);
    chk("stream_start_low", 32'(fetch_start), 32'h0);
    chk("stream_ready", 32'(hw_ready), 32'h1);

    // 32-bit addi assembled from two halfwords.
    drive(1, 16'h0093, 0);
    chk("addi_half_valid", 32'(instr_valid), 32'h0);
    drive(1, 16'h0010, 0);
    chk("addi_valid", 32'(instr_valid), 32'h1);
    chk("addi_instr", instr_out, 32'h00100093);
    chk("addi_comp", 32'(instr_compressed), 32'h0);
    chk("addi_pc", 32'(pc_out), 32'h0);
    drive(0, 16'h0, 1);
    chk("addi_pc_after", 32'(pc_out), 32'h2);
    chk("addi_empty", 32'(instr_valid), 32'h0);

    // Compressed followed by a 32-bit instruction.
    drive(1, 16'h4501, 0);
    chk("c_instr", instr_out, 32'h00004501);
    chk("c_comp", 32'(instr_compressed), 32'h1);
    chk("c_pc", 32'(pc_out), 32'h2);
    drive(1, 16'h0513, 0);
    drive(1, 16'h0000, 1);
    chk("li_instr", instr_out, 32'h00000513);
    chk("li_pc", 32'(pc_out), 32'h3);
    drive(0, 16'h0, 1);
    chk("li_pc_after", 32'(pc_out), 32'h5);

    // Fill to capacity; extra data is refused while full.
    drive(1, 16'h0001, 0);
    drive(1, 16'h0005, 0);
    drive(1, 16'h0009, 0);
    drive(1, 16'h000D, 0);
    chk("full_ready", 32'(hw_ready), 32'h0);
    drive(1, 16'h0011, 0);
    chk("full_hold", instr_out, 32'h00000001);
    drive(1, 16'h0011, 1);
    chk("full_pop_instr", instr_out, 32'h00000005);
    chk("full_pop_ready", 32'(hw_ready), 32'h1);
    drive(1, 16'h0011, 1);
    chk("pushpop_instr", instr_out, 32'h00000009);
    chk("pushpop_pc", 32'(pc_out), 32'h7);
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 1);
    chk("drain_valid", 32'(instr_valid), 32'h0);
    chk("drain_pc", 32'(pc_out), 32'd10);

    // Branch with buffered data and hw_valid asserted.
    drive(1, 16'h0021, 0);
    drive(1, 16'h0025, 0);
    drive(1, 16'h0029, 0);
    hw_valid = 1'b1; hw_data = 16'h0031; instr_complete = 1'b1;
    branch = 1'b1; branch_addr = 23'h000100;
    tick();
    chk("br_stop", 32'(fetch_stop), 32'h1);
    chk("br_valid", 32'(instr_valid), 32'h0);
    chk("br_pc", 32'(pc_out), 32'h100);
    drive(1, 16'h0031, 0);
    chk("br_start", 32'(fetch_start), 32'h1);
    chk("br_addr", 32'(fetch_addr), 32'h100);
    drive(0, 16'h0, 0);
    chk("br_no_stale", 32'(instr_valid), 32'h0);
    chk("br_ready", 32'(hw_ready), 32'h1);

    // PC wrap at the top of the address space, then reset mid-stream.
    hw_valid = 1'b0; instr_complete = 1'b0; branch = 1'b1; branch_addr = 23'h7FFFFF;
    tick();
    drive(0, 16'h0, 0);
    drive(0, 16'h0, 0);
    drive(1, 16'h4501, 0);
    chk("wrap_pc_top", 32'(pc_out), 32'h7FFFFF);
    drive(0, 16'h0, 1);
    chk("wrap_pc", 32'(pc_out), 32'h0);
    drive(1, 16'h0001, 0);
    drive(1, 16'h0005, 1);
    chk("pre_rst_pc", 32'(pc_out), 32'h1);
    rstn = 1'b0;
    drive(0, 16'h0, 0);
    chk("midrst_pc", 32'(pc_out), 32'(RST_PC));
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    chk("midrst_ready", 32'(hw_ready), 32'h0);
    rstn = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rstn           = ($urandom_range(0, 299) != 0);
      hw_valid       = ($urandom_range(0, 9) < 6);
      hw_data        = 16'($urandom);
      instr_complete = ($urandom_range(0, 1) == 1);
      branch         = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       branch_addr = 23'h7FFFFE;
        1:       branch_addr = 23'h7FFFFD;
        default: branch_addr = 23'($urandom);
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
